// File: rtl/nios_div_cell.sv
// nios_div_cell: iterative restoring divider, one quotient bit per cycle, signed/unsigned with kill.
module nios_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, d_q, d_d, q_q, q_d, dvs_q, dvs_d, raw_q, raw_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, a_mag, b_mag;
  logic [WIDTH:0]   r_sh, r_sub;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             nq_q, nq_d, nr_q, nr_d, zero_q, zero_d, dz_q, dz_d;
  logic             busy_q, busy_d, done_q, done_d, a_neg, b_neg, ge;
  always_comb begin
    a_neg   = is_signed & dividend[WIDTH-1];
    b_neg   = is_signed & divisor[WIDTH-1];
    a_mag   = a_neg ? -dividend : dividend;
    b_mag   = b_neg ? -divisor : divisor;
    r_sh    = {r_q, d_q[WIDTH-1]};
    r_sub   = r_sh - {1'b0, dvs_q};
    // a borrow out of the (WIDTH+1)-bit subtract means the trial remainder was below the divisor
    ge      = ~r_sub[WIDTH];
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (start && !kill) begin
        state_d = CALC;
        d_d     = a_mag;
        dvs_d   = b_mag;
        raw_d   = dividend;
        nq_d    = a_neg ^ b_neg;
        nr_d    = a_neg;
        zero_d  = divisor == '0;
        r_d     = '0;
        q_d     = '0;
        cnt_d   = CW'(WIDTH);
      end
      CALC: begin
        d_d     = {d_q[WIDTH-2:0], 1'b0};
        r_d     = ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], ge};
        cnt_d   = cnt_q - 1'b1;
        state_d = kill ? IDLE : (cnt_q == CW'(1)) ? FIX : CALC;
      end
      FIX: if (kill) state_d = IDLE;
      else begin
        quo_d   = zero_q ? '1 : nq_q ? -q_q : q_q;
        rem_d   = zero_q ? raw_q : nr_q ? -r_q : r_q;
        dz_d    = zero_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_nios_div_cell.sv
// tb_nios_div_cell: directed divider bench with an expected-result scoreboard.
module tb_nios_div_cell;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0, kill = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, quotient, remainder;
  logic        busy, done, div_by_zero;
  int          passes = 0, checks = 0, fails = 0;
  typedef struct {logic [31:0] q; logic [31:0] r; logic z;} exp_t;
  exp_t sb[$];

  nios_div_cell #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .kill(kill), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cycle 1 is the cycle right after the start edge; done must appear in cycle 34
  task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic ez,
                     input string tag, input int poke);
    int   c = 1, nb = 0;
    bit   seen = 0;
    exp_t e;
    sb.push_back('{eq, er, ez});
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    step();
    start = 1'b0;
    while (c <= 60 && !seen) begin
      if (done) seen = 1;
      else begin
        nb += int'(busy);
        start = (c == poke);
        if (c == poke) begin
          dividend = 32'd9;
          divisor  = 32'd3;
        end
        step();
        c++;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(c), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd33);
    chk({tag, "_q"}, 64'(quotient), 64'(e.q));
    chk({tag, "_r"}, 64'(remainder), 64'(e.r));
    chk({tag, "_z"}, 64'(div_by_zero), 64'(e.z));
    step();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic no_done(input string tag, input int n);
    bit any = 0;
    for (int i = 0; i < n; i++) begin
      any |= done;
      step();
    end
    chk(tag, 64'(any), 64'd0);
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    chk("rst_z", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    step();
    run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u100_7", 0);
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "sm7_2", 0);
    run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, "s7_m2", 0);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "s_ovf", 0);
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "u_big", 0);
    run(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, "u_dz", 0);
    run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "overlap", 5);
    no_done("overlap_no_extra", 40);
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    start     = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_busy", 64'(busy), 64'd0);
    no_done("kill_no_done", 40);
    chk("kill_q", 64'(quotient), 64'd14);
    chk("kill_r", 64'(remainder), 64'd2);
    start = 1'b1;
    kill  = 1'b1;
    step();
    start = 1'b0;
    kill  = 1'b0;
    chk("killstart_busy", 64'(busy), 64'd0);
    run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "u9_3", 0);
    dividend = 32'h1234;
    divisor  = 32'd5;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_q", 64'(quotient), 64'd0);
    chk("mrst_r", 64'(remainder), 64'd0);
    chk("mrst_z", 64'(div_by_zero), 64'd0);
    no_done("mrst_no_done", 40);
    run(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, "u_max_1", 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
